// File: rtl/hazard_forward_unit_pkg.sv
// Shared encodings for the hazard/forwarding unit: bypass selects,
// stage write-enable codes and scoreboard FSM states.
package hazard_forward_unit_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam logic [1:0] W_NONE  = 2'b00;
  localparam logic [1:0] W_RD    = 2'b01;
  localparam logic [1:0] W_RD_R0 = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } sb_state_t;

endpackage

// File: rtl/hazard_forward_unit_mc_scoreboard.sv
// Tracks one in-flight multi-cycle op: FSM, latency counter, pending
// destination bits and a per-operand pending lookup for the ID stage.
module hazard_forward_unit_mc_scoreboard
  import hazard_forward_unit_pkg::*;
#(
  parameter int AW       = 4,
  parameter int NUM_SRC  = 2,
  parameter int MC_LAT   = 4,
  parameter int MC_WR_R0 = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [AW-1:0]         mc_rd,
  input  logic [NUM_SRC*AW-1:0] srcs,
  output logic [NUM_SRC-1:0]    src_pend,
  output logic                  r0_pend,
  output logic                  mc_busy,
  output logic                  mc_done
);

  localparam int CW = $clog2(MC_LAT + 1);
  localparam int NR = 2 ** AW;

  sb_state_t     state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [NR-1:0] pending, pending_next;
  logic          done_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      pending <= '0;
      mc_done <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      pending <= pending_next;
      mc_done <= done_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    pending_next = pending;
    done_next    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next          = ST_BUSY;
          cnt_next            = CW'(MC_LAT - 1);
          pending_next        = '0;
          pending_next[mc_rd] = 1'b1;
          if (MC_WR_R0 != 0) pending_next[0] = 1'b1;
        end
      end
      ST_BUSY: begin
        // The done cycle is the last one the result is held back; the
        // write-first regfile serves readers from the next cycle on.
        if (mc_done) begin
          state_next   = ST_IDLE;
          cnt_next     = '0;
          pending_next = '0;
        end else begin
          if (cnt != '0) cnt_next = cnt - CW'(1);
          if (cnt == CW'(1)) done_next = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mc_busy = (state == ST_BUSY);
    r0_pend = pending[0];
    for (int k = 0; k < NUM_SRC; k++) begin
      src_pend[k] = pending[srcs[k*AW +: AW]];
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// ID-stage hazard unit: per-operand EX/MEM/WB bypass selection, load-use
// stall and multi-cycle op interlock via the scoreboard sub-module.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int AW       = 4,
  parameter int NUM_SRC  = 2,
  parameter int MC_LAT   = 4,
  parameter int MC_WR_R0 = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_SRC*AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]    id_src_used,
  input  logic                  id_uses_r0,
  input  logic                  id_mc_start,
  input  logic [AW-1:0]         id_mc_rd,
  input  logic [1:0]            exW,
  input  logic [1:0]            mW,
  input  logic [1:0]            wbW,
  input  logic [AW-1:0]         exRegDest,
  input  logic [AW-1:0]         mRegDest,
  input  logic [AW-1:0]         wbRegDest,
  input  logic                  ex_is_load,
  output logic [NUM_SRC*2-1:0]  src_fwd,
  output logic [1:0]            R0Fwd,
  output logic                  stall,
  output logic                  mc_busy,
  output logic                  mc_done
);

  logic [NUM_SRC-1:0] src_pend;
  logic               r0_pend;
  logic               ex_hit;
  logic               pend_hit;
  logic               luse;

  // A stage writing Rd+R0 also satisfies an R0 read regardless of Rd.
  function automatic logic stage_match(input logic [1:0] w, input logic [AW-1:0] dest,
                                       input logic [AW-1:0] r);
    return (w[0] && (dest == r)) || ((r == '0) && (w == W_RD_R0));
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [AW-1:0] r);
    if (stage_match(exW, exRegDest, r))       return FWD_EX;
    else if (stage_match(mW, mRegDest, r))    return FWD_MEM;
    else if (stage_match(wbW, wbRegDest, r))  return FWD_WB;
    else                                      return FWD_RF;
  endfunction

  always_comb begin
    src_fwd  = '0;
    R0Fwd    = FWD_RF;
    ex_hit   = 1'b0;
    pend_hit = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (id_src_used[k]) begin
        src_fwd[k*2 +: 2] = fwd_sel(id_src[k*AW +: AW]);
        if (stage_match(exW, exRegDest, id_src[k*AW +: AW])) ex_hit = 1'b1;
        if (src_pend[k]) pend_hit = 1'b1;
      end
    end
    if (id_uses_r0) begin
      R0Fwd = fwd_sel('0);
      if (stage_match(exW, exRegDest, '0)) ex_hit = 1'b1;
      if (r0_pend) pend_hit = 1'b1;
    end
  end

  // Load data is not available until MEM, so an EX match on a load costs one bubble.
  assign luse  = ex_is_load & exW[0] & ex_hit;
  assign stall = luse | pend_hit | (id_mc_start & mc_busy);

  hazard_forward_unit_mc_scoreboard #(
    .AW       (AW),
    .NUM_SRC  (NUM_SRC),
    .MC_LAT   (MC_LAT),
    .MC_WR_R0 (MC_WR_R0)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .start    (id_mc_start & ~stall),
    .mc_rd    (id_mc_rd),
    .srcs     (id_src),
    .src_pend (src_pend),
    .r0_pend  (r0_pend),
    .mc_busy  (mc_busy),
    .mc_done  (mc_done)
  );

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: forwarding vector table plus
// load-use, multi-cycle op, back-to-back op and mid-op reset sequences.
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] id_src;
  logic [1:0] id_src_used;
  logic       id_uses_r0;
  logic       id_mc_start;
  logic [3:0] id_mc_rd;
  logic [1:0] exW, mW, wbW;
  logic [3:0] exRegDest, mRegDest, wbRegDest;
  logic       ex_is_load;
  logic [3:0] src_fwd;
  logic [1:0] R0Fwd;
  logic       stall, mc_busy, mc_done;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_forward_unit #(.AW(4), .NUM_SRC(2), .MC_LAT(4), .MC_WR_R0(1)) dut (
    .clk(clk), .rst(rst), .id_src(id_src), .id_src_used(id_src_used),
    .id_uses_r0(id_uses_r0), .id_mc_start(id_mc_start), .id_mc_rd(id_mc_rd),
    .exW(exW), .mW(mW), .wbW(wbW), .exRegDest(exRegDest), .mRegDest(mRegDest),
    .wbRegDest(wbRegDest), .ex_is_load(ex_is_load), .src_fwd(src_fwd),
    .R0Fwd(R0Fwd), .stall(stall), .mc_busy(mc_busy), .mc_done(mc_done)
  );

  typedef struct {
    logic [7:0] src;
    logic [1:0] used;
    logic       r0;
    logic [1:0] ew;
    logic [3:0] ed;
    logic [1:0] mw;
    logic [3:0] md;
    logic [1:0] ww;
    logic [3:0] wd;
    logic       ld;
    logic [3:0] efwd;
    logic [1:0] er0;
    logic       estl;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    id_src = '0; id_src_used = '0; id_uses_r0 = 1'b0; id_mc_start = 1'b0;
    id_mc_rd = '0; exW = '0; mW = '0; wbW = '0; exRegDest = '0;
    mRegDest = '0; wbRegDest = '0; ex_is_load = 1'b0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs checked 3 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            src    used  r0  ew     ed  mw     md  ww     wd  ld   efwd     er0    stl
    tbl[0]  = '{8'h22, 2'b11, 0, 2'b01, 2, 2'b01, 2, 2'b01, 2, 0, 4'b0101, 2'b00, 0};
    tbl[1]  = '{8'h03, 2'b11, 1, 2'b00, 0, 2'b01, 3, 2'b11, 5, 0, 4'b1110, 2'b11, 0};
    tbl[2]  = '{8'h04, 2'b01, 0, 2'b01, 4, 2'b00, 0, 2'b00, 0, 1, 4'b0001, 2'b00, 1};
    tbl[3]  = '{8'h02, 2'b01, 0, 2'b10, 2, 2'b00, 0, 2'b00, 0, 1, 4'b0000, 2'b00, 0};
    tbl[4]  = '{8'h55, 2'b00, 0, 2'b01, 5, 2'b00, 0, 2'b00, 0, 1, 4'b0000, 2'b00, 0};
    tbl[5]  = '{8'h77, 2'b10, 0, 2'b01, 7, 2'b01, 7, 2'b01, 7, 0, 4'b0100, 2'b00, 0};
    tbl[6]  = '{8'h09, 2'b01, 0, 2'b00, 0, 2'b01, 9, 2'b01, 9, 0, 4'b0010, 2'b00, 0};
    tbl[7]  = '{8'h00, 2'b00, 1, 2'b11, 3, 2'b00, 0, 2'b00, 0, 1, 4'b0000, 2'b01, 1};
    tbl[8]  = '{8'h00, 2'b00, 1, 2'b01, 0, 2'b11, 5, 2'b00, 0, 0, 4'b0000, 2'b01, 0};
    tbl[9]  = '{8'h00, 2'b00, 0, 2'b11, 3, 2'b00, 0, 2'b00, 0, 0, 4'b0000, 2'b00, 0};
    tbl[10] = '{8'h00, 2'b01, 0, 2'b00, 0, 2'b00, 0, 2'b11, 8, 0, 4'b0011, 2'b00, 0};

    clr();
    rst = 1'b1;
    tick();
    tick();
    #3;
    chk("reset_busy", 32'(mc_busy), 32'd0);
    chk("reset_done", 32'(mc_done), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    tick();
    rst = 1'b0;

    foreach (tbl[i]) begin
      tick();
      id_src = tbl[i].src; id_src_used = tbl[i].used; id_uses_r0 = tbl[i].r0;
      exW = tbl[i].ew; exRegDest = tbl[i].ed; mW = tbl[i].mw; mRegDest = tbl[i].md;
      wbW = tbl[i].ww; wbRegDest = tbl[i].wd; ex_is_load = tbl[i].ld;
      #3;
      chk($sformatf("vec%0d_src_fwd", i), 32'(src_fwd), 32'(tbl[i].efwd));
      chk($sformatf("vec%0d_r0fwd", i), 32'(R0Fwd), 32'(tbl[i].er0));
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(tbl[i].estl));
    end

    // Load-use: one stall, then the load sits in MEM and is bypassed from there.
    tick(); clr();
    ex_is_load = 1'b1; exW = 2'b01; exRegDest = 4'd4; id_src = 8'h04; id_src_used = 2'b01;
    #3; chk("luse_stall", 32'(stall), 32'd1);
    tick(); clr();
    mW = 2'b01; mRegDest = 4'd4; id_src = 8'h04; id_src_used = 2'b01;
    #3; chk("luse_after_stall", 32'(stall), 32'd0);
    chk("luse_after_fwd", 32'(src_fwd[1:0]), 32'd2);

    // Load-use coinciding with a multi-cycle start: the start is not accepted.
    tick(); clr();
    ex_is_load = 1'b1; exW = 2'b01; exRegDest = 4'd4; id_src = 8'h04; id_src_used = 2'b01;
    id_mc_start = 1'b1; id_mc_rd = 4'd6;
    #3; chk("luse_start_stall", 32'(stall), 32'd1);
    tick(); clr();
    #3; chk("luse_start_not_busy", 32'(mc_busy), 32'd0);

    // Single op: t0 start, busy t1..t4, done at t4, readers released at t5.
    tick(); clr();
    id_mc_start = 1'b1; id_mc_rd = 4'd6;
    #3; chk("mc_t0_stall", 32'(stall), 32'd0);
    chk("mc_t0_busy", 32'(mc_busy), 32'd0);
    for (int t = 1; t <= 4; t++) begin
      tick(); clr();
      case (t)
        1, 4: begin id_src = 8'h06; id_src_used = 2'b01; end
        2:    id_uses_r0 = 1'b1;
        default: begin id_src = 8'h70; id_src_used = 2'b10; end
      endcase
      #3;
      chk($sformatf("mc_t%0d_stall", t), 32'(stall), (t == 3) ? 32'd0 : 32'd1);
      chk($sformatf("mc_t%0d_busy", t), 32'(mc_busy), 32'd1);
      chk($sformatf("mc_t%0d_done", t), 32'(mc_done), (t == 4) ? 32'd1 : 32'd0);
    end
    tick(); clr();
    id_src = 8'h06; id_src_used = 2'b01; id_uses_r0 = 1'b1;
    #3; chk("mc_t5_stall", 32'(stall), 32'd0);
    chk("mc_t5_busy", 32'(mc_busy), 32'd0);
    chk("mc_t5_done", 32'(mc_done), 32'd0);

    // Back-to-back ops: second start held t2..t4, accepted t5, done at t9.
    tick(); clr();
    id_mc_start = 1'b1; id_mc_rd = 4'd6;
    #3; chk("b2b_t0_stall", 32'(stall), 32'd0);
    tick(); clr();
    for (int t = 2; t <= 5; t++) begin
      tick(); clr();
      id_mc_start = 1'b1; id_mc_rd = 4'd9;
      #3; chk($sformatf("b2b_t%0d_stall", t), 32'(stall), (t == 5) ? 32'd0 : 32'd1);
    end
    for (int t = 6; t <= 10; t++) begin
      tick(); clr();
      #3;
      chk($sformatf("b2b_t%0d_busy", t), 32'(mc_busy), (t == 10) ? 32'd0 : 32'd1);
      chk($sformatf("b2b_t%0d_done", t), 32'(mc_done), (t == 9) ? 32'd1 : 32'd0);
    end

    // Reset at t2 abandons the op; the R6 reader is released at t3.
    tick(); clr();
    id_mc_start = 1'b1; id_mc_rd = 4'd6;
    tick(); clr();
    #3; chk("rst_t1_busy", 32'(mc_busy), 32'd1);
    tick(); clr();
    rst = 1'b1; id_src = 8'h06; id_src_used = 2'b01;
    #3; chk("rst_t2_stall", 32'(stall), 32'd1);
    for (int t = 3; t <= 6; t++) begin
      tick(); clr();
      rst = 1'b0; id_src = 8'h06; id_src_used = 2'b01;
      #3;
      chk($sformatf("rst_t%0d_stall", t), 32'(stall), 32'd0);
      chk($sformatf("rst_t%0d_busy", t), 32'(mc_busy), 32'd0);
      chk($sformatf("rst_t%0d_done", t), 32'(mc_done), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
